// File: rtl/parking_sensor_debouncer.sv
// Two-channel synchroniser/debouncer for the parking-lot beam sensors (a = outer, b = inner).
// Optional rejected-glitch counter on glitch_cnt when PARK_GLITCH_COUNT_EN is defined.
module parking_sensor_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_raw,
    input  logic       b_raw,
    output logic       a,
    output logic       b,
    output logic       a_chg,
    output logic       b_chg
`ifdef PARK_GLITCH_COUNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Index 0 is channel a, index 1 is channel b; the two never interact.
    logic [1:0]       raw_in;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       lvl;
    logic [1:0]       chg;
    logic [1:0]       pending;
    logic [1:0]       accept;
    logic [1:0]       lvl_nxt;
    logic [1:0]       chg_nxt;
    logic [CNT_W-1:0] cnt     [2];
    logic [CNT_W-1:0] cnt_nxt [2];

    assign raw_in = {b_raw, a_raw};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
        end
    end

    // A pending change is accepted only after the counter has seen it STABLE_CYCLES times.
    always_comb begin
        pending    = '0;
        accept     = '0;
        lvl_nxt    = lvl;
        chg_nxt    = '0;
        cnt_nxt[0] = '0;
        cnt_nxt[1] = '0;
        for (int i = 0; i < 2; i++) begin
            pending[i] = (s2[i] != lvl[i]);
            accept[i]  = pending[i] && (cnt[i] == CNT_LAST);
            if (accept[i]) begin
                lvl_nxt[i] = s2[i];
                chg_nxt[i] = 1'b1;
            end
            if (pending[i] && !accept[i]) begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvl    <= '0;
            chg    <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            lvl    <= lvl_nxt;
            chg    <= chg_nxt;
            cnt[0] <= cnt_nxt[0];
            cnt[1] <= cnt_nxt[1];
        end
    end

    assign a     = lvl[0];
    assign b     = lvl[1];
    assign a_chg = chg[0];
    assign b_chg = chg[1];

`ifdef PARK_GLITCH_COUNT_EN
    logic [1:0] glitch;
    logic [8:0] glitch_sum;

    // A glitch is a partially counted change whose input fell back before acceptance.
    always_comb begin
        glitch = '0;
        for (int i = 0; i < 2; i++) begin
            glitch[i] = !pending[i] && (cnt[i] != '0);
        end
        glitch_sum = {1'b0, glitch_cnt} + 9'(glitch[0]) + 9'(glitch[1]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_cnt <= '0;
        end else if (glitch_sum > 9'd255) begin
            glitch_cnt <= 8'hFF;
        end else begin
            glitch_cnt <= glitch_sum[7:0];
        end
    end
`endif

endmodule
